// File: rtl/serial_pkg.sv
// Shared types and frame constants for the asynchronous-serial transmitter.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: tick is high on the last clock cycle of every serial bit.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial framing transmitter: start bit, 8 data bits LSB first, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              tick;
  logic              clear;
  logic              tx_q;
  logic              done_q;

  // Counter is held at zero while idle so the start bit gets a full period.
  assign clear = (state == IDLE);

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .tick  (tick)
  );

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign tx_o    = tx_q;
  assign done_o  = done_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= IDLE;
      tx_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= IDLE_LEVEL;
          if (valid_i) begin
            shreg <= data_i;
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            // tx_q is loaded with the bit that becomes shreg[0] after this shift.
            shreg   <= {1'b0, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx_q  <= IDLE_LEVEL;
            end else begin
              tx_q <= shreg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
